// File: rtl/lcd_bus_sched_if.sv
// Requester handshakes plus the character-LCD write bus driven by lcd_bus_sched.
// The scheduler uses the slave view; requesters and benches use the master view.
interface lcd_bus_sched_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       ready;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output gnt0, gnt1, ready, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  gnt0, gnt1, ready, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_bus_sched.sv
// Two-requester write scheduler for an HD44780-style character LCD: runs the
// power-up init sequence, then arbitrates writes and times the E strobe.
module lcd_bus_sched #(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int WAIT_SHORT = 40,
  parameter int WAIT_LONG  = 1640,
  parameter int INIT_WAIT  = 15000
) (
  input  logic           clk,
  input  logic           rst,
  lcd_bus_sched_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXV = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, WAIT_SHORT)),
                             max2(WAIT_LONG, INIT_WAIT));
  localparam int CW   = ($clog2(MAXV + 1) > 16) ? $clog2(MAXV + 1) : 16;

  // Counter load values are "cycles - 1": a state ends when the counter reads zero.
  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_WSHRT = CW'(WAIT_SHORT - 1);
  localparam logic [CW-1:0] L_WLONG = CW'(WAIT_LONG - 1);
  localparam logic [CW-1:0] L_INIT  = CW'(INIT_WAIT - 1);

  typedef enum logic [2:0] {
    S_INIT_DLY,
    S_INIT_CMD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    r_init_idx;
  logic [1:0]    w_init_idx_next;
  logic          r_in_init;
  logic          w_in_init_next;
  logic          r_last;
  logic          w_last_next;
  logic          r_ready;
  logic          w_ready_next;
  logic          r_busy;
  logic          r_lcd_e;
  logic          r_lcd_rs;
  logic          w_lcd_rs_next;
  logic [7:0]    r_lcd_data;
  logic [7:0]    w_lcd_data_next;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_cnt_done;
  logic          w_long;
  logic [7:0]    w_init_byte;

  assign w_cnt_done = (r_cnt == '0);
  // Clear (0x01) and home (0x02/0x03) need the long execution delay.
  assign w_long     = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0);

  always_comb begin
    w_init_byte = 8'h38;
    case (r_init_idx)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0C;
      2'd2:    w_init_byte = 8'h06;
      default: w_init_byte = 8'h01;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = w_cnt_done ? r_cnt : r_cnt - CW'(1);
    w_init_idx_next = r_init_idx;
    w_in_init_next  = r_in_init;
    w_last_next     = r_last;
    w_ready_next    = r_ready;
    w_lcd_rs_next   = r_lcd_rs;
    w_lcd_data_next = r_lcd_data;
    w_gnt0          = 1'b0;
    w_gnt1          = 1'b0;

    case (r_state)
      S_INIT_DLY: begin
        if (w_cnt_done) w_state_next = S_INIT_CMD;
      end
      S_INIT_CMD: begin
        w_lcd_rs_next   = 1'b0;
        w_lcd_data_next = w_init_byte;
        w_cnt_next      = L_SETUP;
        w_state_next    = S_SETUP;
      end
      S_IDLE: begin
        // r_last == 1 means requester 1 was granted last, so requester 0 wins a tie.
        if (r_ready && bus.req0 && (!bus.req1 || r_last)) begin
          w_gnt0 = 1'b1;
        end else if (r_ready && bus.req1) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_last_next     = w_gnt1;
          w_lcd_rs_next   = w_gnt1 ? bus.rs1 : bus.rs0;
          w_lcd_data_next = w_gnt1 ? bus.data1 : bus.data0;
          w_cnt_next      = L_SETUP;
          w_state_next    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_cnt_done) begin
          w_cnt_next   = L_PULSE;
          w_state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (w_cnt_done) begin
          w_cnt_next   = L_HOLD;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_cnt_done) begin
          w_cnt_next   = w_long ? L_WLONG : L_WSHRT;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_cnt_done) begin
          if (!r_in_init) begin
            w_state_next = S_IDLE;
          end else if (r_init_idx == 2'd3) begin
            w_in_init_next = 1'b0;
            w_ready_next   = 1'b1;
            w_state_next   = S_IDLE;
          end else begin
            w_init_idx_next = r_init_idx + 2'd1;
            w_state_next    = S_INIT_CMD;
          end
        end
      end
      default: begin
        w_cnt_next   = L_INIT;
        w_state_next = S_INIT_DLY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT_DLY;
      r_cnt      <= L_INIT;
      r_init_idx <= 2'd0;
      r_in_init  <= 1'b1;
      r_last     <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_init_idx <= w_init_idx_next;
      r_in_init  <= w_in_init_next;
      r_last     <= w_last_next;
      r_ready    <= w_ready_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_lcd_e    <= (w_state_next == S_PULSE);
      r_lcd_rs   <= w_lcd_rs_next;
      r_lcd_data <= w_lcd_data_next;
    end
  end

  // Grants are decoded from the registered IDLE state so a request can be
  // accepted in the very cycle ready first goes high.
  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.lcd_e    = r_lcd_e;
  assign bus.lcd_rs   = r_lcd_rs;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = r_lcd_data;

endmodule
